// File: rtl/vec_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : vec_alu_pipe
// Purpose  : Pipelined LANES-wide vector ALU. It takes one command, then
//            streams operand beats to result beats through two register
//            stages with valid/ready backpressure.
// Revision : 1.0  initial release
// ============================================================================
module vec_alu_pipe #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int VLEN_W = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [3:0]                cmd_opcode_i,
  input  logic [VLEN_W-1:0]         cmd_vlen_i,
  input  logic [DATA_W-1:0]         cmd_scalar_i,
  input  logic                      cmd_sat_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [LANES*DATA_W-1:0]   in_a_i,
  input  logic [LANES*DATA_W-1:0]   in_b_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [LANES*DATA_W-1:0]   out_data_o,
  output logic                      out_last_o,
  output logic                      done_o,
  output logic                      err_op_o,
  output logic                      busy_o
);

  localparam logic [3:0] OP_ADD_VV  = 4'b0001;
  localparam logic [3:0] OP_SUB_VV  = 4'b0010;
  localparam logic [3:0] OP_XOR_VS  = 4'b0101;
  localparam logic [3:0] OP_SHL_VS  = 4'b0110;
  localparam logic [3:0] OP_SHR_VS  = 4'b0111;
  localparam logic [3:0] OP_ROTL_VS = 4'b1000;
  localparam logic [3:0] OP_ROTR_VS = 4'b1001;
  localparam logic [3:0] OP_ADD_VS  = 4'b1010;
  localparam logic [3:0] OP_SUB_VS  = 4'b1011;
  localparam logic [3:0] OP_OFS_VV  = 4'b1111;

  // Element width as a DATA_W-bit value, for shift/rotate amount compares.
  localparam logic [DATA_W-1:0] c_ELEM_W = DATA_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                    state_q;
  logic [3:0]                op_q;
  logic [DATA_W-1:0]         scalar_q;
  logic                      sat_q;
  logic [VLEN_W-1:0]         rem_q;
  logic                      done_q;
  logic                      err_q;

  logic                      s1_valid_q;
  logic                      s1_last_q;
  logic [LANES*DATA_W-1:0]   s1_a_q;
  logic [LANES*DATA_W-1:0]   s1_b_q;
  logic                      out_valid_q;
  logic                      out_last_q;
  logic [LANES*DATA_W-1:0]   out_data_q;

  logic                      stall;
  logic                      in_fire;
  logic                      use_scalar_b;
  logic [LANES*DATA_W-1:0]   result_d;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      OP_ADD_VV, OP_SUB_VV, OP_XOR_VS, OP_SHL_VS, OP_SHR_VS,
      OP_ROTL_VS, OP_ROTR_VS, OP_ADD_VS, OP_SUB_VS, OP_OFS_VV: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  endfunction

  // One element: y is the second arithmetic operand (b or the scalar),
  // s is always the latched scalar used as shift/rotate amount or xor mask.
  function automatic logic [DATA_W-1:0] lane_op(
    input logic [3:0]        op,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] y,
    input logic [DATA_W-1:0] s,
    input logic              sat
  );
    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   dif;
    logic [DATA_W-1:0] amt;
    logic [DATA_W-1:0] res;
    sum = {1'b0, a} + {1'b0, y};
    dif = {1'b0, a} - {1'b0, y};
    amt = s % c_ELEM_W;
    res = '0;
    case (op)
      OP_ADD_VV, OP_ADD_VS: res = (sat && sum[DATA_W]) ? '1 : sum[DATA_W-1:0];
      OP_SUB_VV, OP_SUB_VS: res = (sat && dif[DATA_W]) ? '0 : dif[DATA_W-1:0];
      OP_OFS_VV:  res = sum[DATA_W-1:0];
      OP_XOR_VS:  res = a ^ s;
      OP_SHL_VS:  res = (s >= c_ELEM_W) ? '0 : (a << s);
      OP_SHR_VS:  res = (s >= c_ELEM_W) ? '0 : (a >> s);
      OP_ROTL_VS: res = (amt == '0) ? a : ((a << amt) | (a >> (c_ELEM_W - amt)));
      OP_ROTR_VS: res = (amt == '0) ? a : ((a >> amt) | (a << (c_ELEM_W - amt)));
      default:    res = '0;
    endcase
    return res;
  endfunction

  // A held result beat freezes the whole pipe, including the input side.
  assign stall        = out_valid_q && !out_ready_i;
  assign in_ready_o   = (state_q == RUN) && (rem_q != '0) && !stall;
  assign in_fire      = in_valid_i && in_ready_o;
  assign use_scalar_b = (op_q == OP_ADD_VS) || (op_q == OP_SUB_VS);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] a_l;
    logic [DATA_W-1:0] y_l;
    assign a_l = s1_a_q[i*DATA_W +: DATA_W];
    assign y_l = use_scalar_b ? scalar_q : s1_b_q[i*DATA_W +: DATA_W];
    assign result_d[i*DATA_W +: DATA_W] = lane_op(op_q, a_l, y_l, scalar_q, sat_q);
  end

  // Command FSM: latches the command, counts accepted beats, pulses done/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      scalar_q <= '0;
      sat_q    <= 1'b0;
      rem_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q     <= cmd_opcode_i;
            scalar_q <= cmd_scalar_i;
            sat_q    <= cmd_sat_i;
            rem_q    <= cmd_vlen_i;
            if (!is_legal(cmd_opcode_i)) begin
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else if (cmd_vlen_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (in_fire) begin
            rem_q <= rem_q - VLEN_W'(1);
            if (rem_q == VLEN_W'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_valid_q && out_ready_i && out_last_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-stage datapath: stage 1 holds operands, stage 2 holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else if (!stall) begin
      s1_valid_q  <= in_fire;
      s1_last_q   <= in_fire && (rem_q == VLEN_W'(1));
      if (in_fire) begin
        s1_a_q <= in_a_i;
        s1_b_q <= in_b_i;
      end
      out_valid_q <= s1_valid_q;
      out_last_q  <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        out_data_q <= result_d;
      end
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign done_o      = done_q;
  assign err_op_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_alu_pipe
// Purpose  : Self-checking bench for vec_alu_pipe with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vec_alu_pipe;
  localparam int W  = 8;
  localparam int L  = 4;
  localparam int VW = 6;
  localparam int M  = 256;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [3:0]      cmd_opcode = '0;
  logic [VW-1:0]   cmd_vlen = '0;
  logic [W-1:0]    cmd_scalar = '0;
  logic            cmd_sat = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [L*W-1:0]  in_a = '0;
  logic [L*W-1:0]  in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [L*W-1:0]  out_data;
  logic            out_last;
  logic            done;
  logic            err_op;
  logic            busy;

  vec_alu_pipe #(.DATA_W(W), .LANES(L), .VLEN_W(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_opcode_i(cmd_opcode), .cmd_vlen_i(cmd_vlen),
    .cmd_scalar_i(cmd_scalar), .cmd_sat_i(cmd_sat),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last),
    .done_o(done), .err_op_o(err_op), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: 0 = always 1, 1 = random, 2 = 1-0-0-1 pattern, 3 = always 0
  int rdy_mode = 0;
  initial begin
    int pc;
    pc = 0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 1) == 1);
        2: out_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
        default: out_ready = 1'b0;
      endcase
      pc++;
    end
  end

  // Observation records (written only here).
  logic [L*W-1:0] out_dq[$];
  bit             out_lq[$];
  int             out_cq[$];
  int             in_cq[$];
  int             cmd_cq[$];
  int             done_cq[$];
  int             err_cnt = 0;
  int             ov_cnt = 0;
  int             stab_err = 0;
  bit             prev_stall = 1'b0;
  logic [L*W-1:0] prev_data = '0;
  logic           prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) cmd_cq.push_back(cyc);
      if (in_valid && in_ready) in_cq.push_back(cyc);
      if (out_valid && out_ready) begin
        out_dq.push_back(out_data);
        out_lq.push_back(out_last);
        out_cq.push_back(cyc);
      end
      if (done) done_cq.push_back(cyc);
      if (err_op) err_cnt++;
      if (out_valid) ov_cnt++;
      if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last))
        stab_err++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  logic [L*W-1:0] va[16];
  logic [L*W-1:0] vb[16];

  // Element rule straight from the opcode table, in plain integer arithmetic.
  function automatic logic [W-1:0] ref_elem(input logic [3:0] op, input int a, input int b,
                                            input int s, input bit sat);
    int r;
    int amt;
    logic [W-1:0] av;
    logic [W-1:0] rv;
    r  = 0;
    av = a[W-1:0];
    rv = '0;
    case (op)
      4'h1: begin r = a + b; if (sat && r > M - 1) r = M - 1; end
      4'hF: r = a + b;
      4'h2: begin r = a - b; if (sat && r < 0) r = 0; end
      4'hA: begin r = a + s; if (sat && r > M - 1) r = M - 1; end
      4'hB: begin r = a - s; if (sat && r < 0) r = 0; end
      4'h5: r = a ^ s;
      4'h6: r = (s >= W) ? 0 : a * (1 << s);
      4'h7: r = (s >= W) ? 0 : a / (1 << s);
      4'h8, 4'h9: begin
        amt = (op == 4'h8) ? (s % W) : ((W - (s % W)) % W);
        for (int k = 0; k < W; k++) rv[(k + amt) % W] = av[k];
        r = int'(rv);
      end
      default: r = 0;
    endcase
    return W'(r & (M - 1));
  endfunction

  function automatic logic [L*W-1:0] ref_word(input logic [3:0] op, input logic [L*W-1:0] a,
                                              input logic [L*W-1:0] b, input logic [W-1:0] s,
                                              input bit sat);
    logic [L*W-1:0] r;
    r = '0;
    for (int l = 0; l < L; l++)
      r[l*W +: W] = ref_elem(op, int'(a[l*W +: W]), int'(b[l*W +: W]), int'(s), sat);
    return r;
  endfunction

  function automatic bit legal_op(input logic [3:0] op);
    return op inside {4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
  endfunction

  // Issue one command, stream its beats, wait for done, then check everything.
  task automatic run_cmd(input logic [3:0] op, input int vlen, input logic [W-1:0] s,
                         input bit sat, input bit gaps, input bit chk_lat, input string nm);
    int ob, ib, cb, db, eb, ovb, sb, i, t, exp_n, got_n, ecyc;
    bit legal, hs;
    logic [L*W-1:0] ew;
    legal = legal_op(op);
    exp_n = legal ? vlen : 0;
    ob = out_dq.size(); ib = in_cq.size(); cb = cmd_cq.size(); db = done_cq.size();
    eb = err_cnt; ovb = ov_cnt; sb = stab_err;
    cmd_opcode = op; cmd_vlen = VW'(vlen); cmd_scalar = s; cmd_sat = sat; cmd_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clk); hs = cmd_ready;
      @(posedge clk); #1; t++;
    end while (!hs && t < 50);
    cmd_valid = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL %s cmd_accept: cmd_ready=0 required 1 within 50 cycles", nm);
    end
    if (exp_n > 0) begin
      i = 0; t = 0;
      while (i < vlen && t < 400) begin
        in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        in_a = va[i]; in_b = vb[i];
        @(negedge clk); hs = in_valid && in_ready;
        @(posedge clk); #1;
        if (hs) i++;
        t++;
      end
      in_valid = 1'b0;
      checks++;
      if (i != vlen) begin
        failures++;
        $display("FAIL %s beats_accepted: got %0d required %0d", nm, i, vlen);
      end
    end else begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    end
    t = 0;
    while (done_cq.size() == db && t < 400) begin @(posedge clk); #1; t++; end
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;

    got_n = out_dq.size() - ob;
    checks++;
    if (got_n != exp_n) begin
      failures++;
      $display("FAIL %s out_beats: got %0d required %0d", nm, got_n, exp_n);
    end
    for (int k = 0; k < exp_n && k < got_n; k++) begin
      ew = ref_word(op, va[k], vb[k], s, sat);
      checks++;
      if (out_dq[ob+k] !== ew) begin
        failures++;
        $display("FAIL %s data[%0d]: got %h required %h", nm, k, out_dq[ob+k], ew);
      end
      checks++;
      if (out_lq[ob+k] !== (k == exp_n - 1)) begin
        failures++;
        $display("FAIL %s last[%0d]: got %0b required %0b", nm, k, out_lq[ob+k], (k == exp_n - 1));
      end
      if (chk_lat && (in_cq.size() > ib + k)) begin
        checks++;
        if (out_cq[ob+k] != in_cq[ib+k] + 2) begin
          failures++;
          $display("FAIL %s latency[%0d]: got %0d required 2", nm, k, out_cq[ob+k] - in_cq[ib+k]);
        end
      end
    end
    checks++;
    if (done_cq.size() - db != 1) begin
      failures++;
      $display("FAIL %s done_count: got %0d required 1", nm, done_cq.size() - db);
    end else begin
      if (exp_n > 0 && got_n == exp_n) ecyc = out_cq[ob+exp_n-1] + 1;
      else if (cmd_cq.size() > cb) ecyc = cmd_cq[cb] + 1;
      else ecyc = -1;
      checks++;
      if (done_cq[db] != ecyc) begin
        failures++;
        $display("FAIL %s done_cycle: got %0d required %0d", nm, done_cq[db], ecyc);
      end
    end
    checks++;
    if (err_cnt - eb != (legal ? 0 : 1)) begin
      failures++;
      $display("FAIL %s err_op_count: got %0d required %0d", nm, err_cnt - eb, legal ? 0 : 1);
    end
    checks++;
    if (in_cq.size() - ib != exp_n) begin
      failures++;
      $display("FAIL %s in_handshakes: got %0d required %0d", nm, in_cq.size() - ib, exp_n);
    end
    if (exp_n == 0) begin
      checks++;
      if (ov_cnt != ovb) begin
        failures++;
        $display("FAIL %s out_valid_seen: got %0d cycles required 0", nm, ov_cnt - ovb);
      end
    end
    checks++;
    if (stab_err != sb) begin
      failures++;
      $display("FAIL %s stall_stability: got %0d violations required 0", nm, stab_err - sb);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset in_ready: got %b required 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset out_data: got %h required 0", out_data); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset out_last: got %b required 0", out_last); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset done: got %b required 0", done); end
    checks++; if (err_op !== 1'b0) begin failures++; $display("FAIL reset err_op: got %b required 0", err_op); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset busy: got %b required 0", busy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith_vectors();
    rdy_mode = 0;
    for (int k = 0; k < 3; k++) begin va[k] = 32'h7F01F010; vb[k] = 32'h01FF2020; end
    run_cmd(4'h1, 3, 8'h00, 1'b0, 1'b0, 1'b1, "add_vv");
    run_cmd(4'h1, 3, 8'h00, 1'b1, 1'b0, 1'b1, "add_vv_sat");
    run_cmd(4'hF, 3, 8'h00, 1'b1, 1'b0, 1'b1, "offset_add");
    va[0] = 32'h05050505; vb[0] = 32'h10101010;
    run_cmd(4'h2, 1, 8'h00, 1'b1, 1'b0, 1'b1, "sub_vv_sat");
    run_cmd(4'h2, 1, 8'h00, 1'b0, 1'b0, 1'b1, "sub_vv_wrap");
    va[0] = 32'hF0FE0102;
    run_cmd(4'hA, 1, 8'h10, 1'b1, 1'b0, 1'b1, "add_vs_sat");
    run_cmd(4'hB, 1, 8'h03, 1'b1, 1'b0, 1'b1, "sub_vs_sat");
  endtask

  task automatic test_shift_rotate();
    rdy_mode = 0;
    va[0] = 32'h81818181; vb[0] = $urandom;
    run_cmd(4'h8, 1, 8'd3, 1'b0, 1'b0, 1'b1, "rotl_3");
    run_cmd(4'h9, 1, 8'd11, 1'b0, 1'b0, 1'b1, "rotr_11");
    run_cmd(4'h8, 1, 8'd16, 1'b0, 1'b0, 1'b1, "rotl_16");
    run_cmd(4'h6, 1, 8'd9, 1'b0, 1'b0, 1'b1, "shl_9");
    run_cmd(4'h6, 1, 8'd8, 1'b0, 1'b0, 1'b1, "shl_8");
    va[0] = 32'hF0F0F0F0;
    run_cmd(4'h7, 1, 8'd4, 1'b0, 1'b0, 1'b1, "shr_4");
    run_cmd(4'h5, 1, 8'h5A, 1'b0, 1'b0, 1'b1, "xor_vs");
  endtask

  task automatic test_stall();
    for (int k = 0; k < 4; k++) begin va[k] = $urandom; vb[k] = $urandom; end
    rdy_mode = 2;
    run_cmd(4'h1, 4, 8'h00, 1'b0, 1'b1, 1'b0, "stall_pattern");
    rdy_mode = 0;
  endtask

  task automatic test_random();
    logic [3:0] ops[10];
    ops = '{4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hF};
    for (int n = 0; n < 24; n++) begin
      int vl;
      bit g;
      vl = $urandom_range(1, 12);
      for (int k = 0; k < vl; k++) begin va[k] = $urandom; vb[k] = $urandom; end
      rdy_mode = $urandom_range(0, 1);
      g = ($urandom_range(0, 1) == 1);
      run_cmd(ops[$urandom_range(0, 9)], vl, W'($urandom_range(0, 20)), ($urandom_range(0, 1) == 1),
              g, (rdy_mode == 0), "random");
    end
    rdy_mode = 0;
  endtask

  task automatic test_illegal();
    rdy_mode = 0;
    run_cmd(4'h3, 5, 8'h00, 1'b0, 1'b0, 1'b0, "illegal_0011");
    run_cmd(4'h0, 2, 8'h00, 1'b0, 1'b0, 1'b0, "illegal_0000");
    run_cmd(4'hC, 1, 8'h00, 1'b0, 1'b0, 1'b0, "illegal_1100");
    run_cmd(4'h1, 0, 8'h00, 1'b0, 1'b0, 1'b0, "vlen_zero");
  endtask

  task automatic test_reset_midcmd();
    int db, hs_n, t;
    rdy_mode = 3;
    @(posedge clk); #1;
    va[0] = $urandom; vb[0] = $urandom;
    cmd_opcode = 4'h1; cmd_vlen = VW'(6); cmd_scalar = '0; cmd_sat = 1'b0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hs_n = 0; t = 0;
    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
    while (hs_n < 2 && t < 20) begin
      @(negedge clk); if (in_valid && in_ready) hs_n++;
      @(posedge clk); #1; t++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (hs_n != 2 || out_valid !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset setup: beats=%0d out_valid=%b busy=%b required 2 1 1", hs_n, out_valid, busy);
    end
    db = done_cq.size();
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset out_valid: got %b required 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset busy: got %b required 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL midreset cmd_ready: got %b required 1", cmd_ready); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL midreset out_last: got %b required 0", out_last); end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done_cq.size() != db) begin
      failures++;
      $display("FAIL midreset done_after_reset: got %0d pulses required 0", done_cq.size() - db);
    end
    for (int k = 0; k < 3; k++) begin va[k] = $urandom; vb[k] = $urandom; end
    run_cmd(4'h2, 3, 8'h00, 1'b1, 1'b0, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_arith_vectors();
    test_shift_rotate();
    test_stall();
    test_illegal();
    test_random();
    test_reset_midcmd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/vec_alu_pipe.md
# vec_alu_pipe

Parametrised, pipelined vector ALU that executes one vector command over a stream of LANES-wide element groups per beat. It is the next-generation execution unit of the vector processor: the same opcode map as the existing 8-bit scalar-lane ALU, plus configurable width and lane count, a command handshake, valid/ready operand and result streams with backpressure, optional unsigned saturation and illegal-opcode reporting. It sits between the vector register-file read port (operands) and the write-back stage (results).

## Interface
- DATA_W, 8, element width in bits (≥2)
- LANES, 4, elements processed per beat
- VLEN_W, 6, width of beat count; max 2^VLEN_W-1 beats per command
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid / cmd_ready  in / out  1  command handshake
- cmd_opcode  in  4  operation
- cmd_vlen  in  VLEN_W  number of beats in the command
- cmd_scalar  in  DATA_W  scalar operand for vector-scalar ops
- cmd_sat  in  1  1 = unsigned saturating add/sub
- in_valid / in_ready  in / out  1  operand beat handshake
- in_a, in_b  in  LANES*DATA_W  operand lanes, lane i at bits [i*DATA_W +: DATA_W]
- out_valid / out_ready  out / in  1  result beat handshake
- out_data  out  LANES*DATA_W  result lanes
- out_last  out  1  marks final beat of a command
- done  out  1  one-cycle pulse when command completes
- err_op  out  1  one-cycle pulse, illegal opcode
- busy  out  1  high whenever state ≠ IDLE

## Operation
- Opcodes (vv = lane-wise a op b; vs = a op latched scalar s, in_b ignored): 0001 add vv; 0010 sub vv; 0101 xor vs; 0110 shl vs; 0111 shr vs (logical); 1000 rotl vs; 1001 rotr vs; 1010 add vs; 1011 sub vs; 1111 offset add vv (same as 0001, never saturates). All others illegal.
- Arithmetic modulo 2^DATA_W. With cmd_sat=1, opcodes 0001/0010/1010/1011 clamp: overflow → all-ones, underflow → 0.
- Shifts: amount = s; s ≥ DATA_W yields 0. Rotates: amount = s mod DATA_W; amount 0 returns a unchanged.
- FSM states IDLE, RUN, DRAIN.
- IDLE: cmd_ready=1. On cmd handshake latch opcode, scalar, sat; remaining ← cmd_vlen.
  - illegal opcode: err_op and done pulse next cycle, stay IDLE, no beats consumed.
  - cmd_vlen=0: done pulse next cycle, stay IDLE.
  - else → RUN.
- RUN: in_ready = (remaining ≠ 0) && !stall, stall = out_valid && !out_ready. Each in handshake decrements remaining; accepting the beat with remaining=1 tags it last and moves to DRAIN.
- DRAIN: in_ready=0; when the last-tagged beat handshakes on out, done pulses next cycle and FSM → IDLE.
- cmd_ready=0 in RUN and DRAIN; no command overlap.

## Timing
- Reset values: cmd_ready=1, in_ready=0, out_valid=0, out_data=0, out_last=0, done=0, err_op=0, busy=0; pipeline valids cleared, FSM IDLE.
- Two register stages: stage 1 captures operands, stage 2 holds the computed result (out_data). Beat accepted at edge k is presented with out_valid=1 after edge k+2.
- Throughput 1 beat/cycle when out_ready=1.
- Global stall: while stall, both stages hold; out_data, out_last stable; no beat lost or duplicated.
- in_valid low creates bubbles; bubbles do not assert out_valid.
- done: one cycle, the cycle after the final out handshake (or after command acceptance for vlen=0/illegal). out_last=1 only with the final beat.
- Reset asserted mid-command discards all in-flight beats immediately; no done pulse.

## Test plan
- DATA_W=8, LANES=4, opcode 0001, vlen=3, a lanes 0x10,0xF0,0x01,0x7F, b 0x20,0x20,0xFF,0x01 each beat, out_ready=1 -> 0x30,0x10,0x00,0x80 three beats, latency 2, out_last on beat 3, done next cycle.
- Same with cmd_sat=1 -> 0x30,0xFF,0xFF,0x80; opcode 0010, a=0x05,b=0x10, sat=1 -> 0x00.
- Opcode 1000, s=3, a=0x81 -> 0x0C; 1001, s=11, a=0x81 -> 0x30; 0110, s=9 -> 0x00; 0111, s=4, a=0xF0 -> 0x0F.
- vlen=4 with out_ready toggled 1-0-0-1 and random in_valid gaps -> four beats in order, data stable across stalls, exactly one out_last and one done.
- Opcode 0011 -> err_op and done pulse one cycle, in_ready stays 0, no out_valid; vlen=0 legal opcode -> done only.
- rst_n low during RUN with two beats in flight -> out_valid=0, busy=0, cmd_ready=1 immediately; next command runs normally.
